axil_pattern_gen_master: RTL and testbench

Parametrised AXI4-Lite master traffic generator: the next generation of the translation generator's M00_AXI test master. On an init pulse it writes N pattern words to a target address window, reads them back and compares, counting data mismatches and non-OKAY responses. Unlike the fixed predecessor, it has configurable width, transaction count, base address and data pattern, plus an error counter and a busy flag. It sits between a control/test harness and any AXI4-Lite slave (BRAM, register file, AXI VIP slave).

---
 rtl/axil_pattern_gen_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_axil_pattern_gen_master.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_pattern_gen_master.sv
// AXI4-Lite master traffic generator: writes N pattern words into a target window,
// reads them back, and counts non-OKAY responses and data mismatches.
module axil_pattern_gen_master #(
    parameter int                                C_M_AXI_ADDR_WIDTH   = 32,
    parameter int                                C_M_AXI_DATA_WIDTH   = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]     C_M_TARGET_BASE_ADDR = 32'h4000_0000,
    parameter int                                C_M_TRANSACTIONS_NUM = 4,
    parameter int                                C_PATTERN_MODE       = 0,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0]     C_SEED               = '0
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              INIT_AXI_TXN,
    output logic                              TXN_DONE,
    output logic                              BUSY,
    output logic                              ERROR,
    output logic [15:0]                       ERR_COUNT,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int DW    = C_M_AXI_DATA_WIDTH;
    localparam int BYTES = DW / 8;
    localparam int SHW   = $clog2(DW);
    localparam logic [8:0] LAST = 9'(C_M_TRANSACTIONS_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t         state, state_nx;
    logic [8:0]     idx, idx_nx;
    logic           init_q, init_qq, start;
    logic           awvalid, awvalid_nx, wvalid, wvalid_nx;
    logic           aw_done, aw_done_nx, w_done, w_done_nx;
    logic           bready, bready_nx, arvalid, arvalid_nx, rready, rready_nx;
    logic [AW-1:0]  awaddr, awaddr_nx, araddr, araddr_nx;
    logic [DW-1:0]  wdata, wdata_nx;
    logic           txn_done, txn_done_nx;
    logic [15:0]    err_count, err_count_nx;
    logic           err_clr;
    logic [1:0]     err_inc;
    logic [16:0]    err_sum;
    logic           error;

    function automatic logic [AW-1:0] addr_of(input logic [8:0] i);
        return C_M_TARGET_BASE_ADDR + AW'(i) * AW'(BYTES);
    endfunction

    function automatic logic [DW-1:0] pattern_of(input logic [8:0] i);
        logic [DW-1:0]  inc;
        logic [DW-1:0]  res;
        logic [SHW-1:0] sh;
        inc = C_SEED + DW'(i);
        sh  = i[SHW-1:0];
        case (C_PATTERN_MODE)
            1:       res = DW'(1) << sh;
            2:       res = ~inc;
            default: res = inc;
        endcase
        return res;
    endfunction

    // Two-flop INIT history: a run starts one edge after INIT is first seen high.
    assign start = init_q & ~init_qq;

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        awvalid_nx  = awvalid;
        wvalid_nx   = wvalid;
        aw_done_nx  = aw_done;
        w_done_nx   = w_done;
        bready_nx   = bready;
        arvalid_nx  = arvalid;
        rready_nx   = rready;
        awaddr_nx   = awaddr;
        araddr_nx   = araddr;
        wdata_nx    = wdata;
        txn_done_nx = txn_done;
        err_clr     = 1'b0;
        err_inc     = 2'd0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx    = S_WR_ADDR_DATA;
                    idx_nx      = '0;
                    awvalid_nx  = 1'b1;
                    wvalid_nx   = 1'b1;
                    awaddr_nx   = addr_of('0);
                    wdata_nx    = pattern_of('0);
                    txn_done_nx = 1'b0;
                    err_clr     = 1'b1;
                end
            end
            S_WR_ADDR_DATA: begin
                if (awvalid && M_AXI_AWREADY) begin
                    awvalid_nx = 1'b0;
                    aw_done_nx = 1'b1;
                end
                if (wvalid && M_AXI_WREADY) begin
                    wvalid_nx = 1'b0;
                    w_done_nx = 1'b1;
                end
                if (aw_done_nx && w_done_nx) begin
                    state_nx   = S_WR_RESP;
                    bready_nx  = 1'b1;
                    aw_done_nx = 1'b0;
                    w_done_nx  = 1'b0;
                end
            end
            S_WR_RESP: begin
                if (bready && M_AXI_BVALID) begin
                    bready_nx = 1'b0;
                    err_inc   = 2'(M_AXI_BRESP != 2'b00);
                    if (idx == LAST) begin
                        idx_nx     = '0;
                        state_nx   = S_RD_ADDR;
                        arvalid_nx = 1'b1;
                        araddr_nx  = addr_of('0);
                    end else begin
                        idx_nx     = idx + 9'd1;
                        state_nx   = S_WR_ADDR_DATA;
                        awvalid_nx = 1'b1;
                        wvalid_nx  = 1'b1;
                        awaddr_nx  = addr_of(idx + 9'd1);
                        wdata_nx   = pattern_of(idx + 9'd1);
                    end
                end
            end
            S_RD_ADDR: begin
                if (arvalid && M_AXI_ARREADY) begin
                    arvalid_nx = 1'b0;
                    rready_nx  = 1'b1;
                    state_nx   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rready && M_AXI_RVALID) begin
                    rready_nx = 1'b0;
                    // A bad response and bad data on the same beat count separately.
                    err_inc   = 2'(M_AXI_RRESP != 2'b00) + 2'(M_AXI_RDATA != pattern_of(idx));
                    if (idx == LAST) begin
                        state_nx    = S_DONE;
                        txn_done_nx = 1'b1;
                    end else begin
                        idx_nx     = idx + 9'd1;
                        state_nx   = S_RD_ADDR;
                        arvalid_nx = 1'b1;
                        araddr_nx  = addr_of(idx + 9'd1);
                    end
                end
            end
            S_DONE: begin
                txn_done_nx = 1'b1;
                state_nx    = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        err_sum      = {1'b0, err_count} + 17'(err_inc);
        err_count_nx = err_clr ? 16'd0 : (err_sum[16] ? 16'hFFFF : err_sum[15:0]);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= S_IDLE;
            idx       <= '0;
            init_q    <= 1'b0;
            init_qq   <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= C_M_TARGET_BASE_ADDR;
            araddr    <= C_M_TARGET_BASE_ADDR;
            wdata     <= '0;
            txn_done  <= 1'b0;
            err_count <= '0;
            error     <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            init_q    <= INIT_AXI_TXN;
            init_qq   <= init_q;
            awvalid   <= awvalid_nx;
            wvalid    <= wvalid_nx;
            aw_done   <= aw_done_nx;
            w_done    <= w_done_nx;
            bready    <= bready_nx;
            arvalid   <= arvalid_nx;
            rready    <= rready_nx;
            awaddr    <= awaddr_nx;
            araddr    <= araddr_nx;
            wdata     <= wdata_nx;
            txn_done  <= txn_done_nx;
            err_count <= err_count_nx;
            error     <= (err_count != 16'd0);
        end
    end

    assign BUSY          = (state != S_IDLE) && (state != S_DONE);
    assign TXN_DONE      = txn_done;
    assign ERROR         = error;
    assign ERR_COUNT     = err_count;
    assign M_AXI_AWADDR  = awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid;
    assign M_AXI_WDATA   = wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid;
    assign M_AXI_BREADY  = bready;
    assign M_AXI_ARADDR  = araddr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid;
    assign M_AXI_RREADY  = rready;

endmodule

// File: tb/tb_axil_pattern_gen_master.sv
// Bench: three generator instances (modes 0/1/2), each against a memory slave with
// programmable ready lags, random response delays and fault injection.
module tb_axil_pattern_gen_master;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic init [3];
    logic clr  [3];
    int   aw_lag [3];
    int   w_lag  [3];
    int   bad_wr [3];
    int   bad_rd [3];
    bit   rnd_en [3];

    logic        done [3];
    logic        busy [3];
    logic        error [3];
    logic [15:0] errc [3];
    logic        awvalid [3];
    logic        wvalid [3];
    logic        bready [3];
    logic [31:0] awaddr [3];
    logic [31:0] wdata [3];
    int          wr_cnt [3];
    int          rd_cnt [3];
    int          aw_hs [3];
    int          w_hs [3];
    int          ar_hs [3];
    int          proto [3];
    logic [31:0] wr_addr [3][64];
    logic [31:0] wr_data [3][64];
    logic [31:0] rd_addr [3][64];

    function automatic int n_of(input int g);
        return (g == 0) ? 4 : (g == 1) ? 40 : 5;
    endfunction

    function automatic logic [31:0] seed_of(input int g);
        return (g == 2) ? 32'hFFFF_FFFE : 32'h0;
    endfunction

    // Reference pattern straight from the word-index rules.
    function automatic logic [31:0] pat(input int mode, input logic [31:0] seed, input int i);
        case (mode)
            1:       pat = 32'h1 << (i % 32);
            2:       pat = ~(seed + 32'(i));
            default: pat = seed + 32'(i);
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] s_awaddr, s_wdata, araddr, rdata;
        logic [2:0]  awprot, arprot;
        logic [3:0]  wstrb;
        logic        s_awvalid, awready, s_wvalid, wready, bvalid, s_bready;
        logic        arvalid, arready, rvalid, rready;
        logic [1:0]  bresp, rresp;
        logic        s_done, s_busy, s_error;
        logic [15:0] s_errc;
        int          wc, rc, ahs, whs, arhs, pc, awc, wlc, arc;
        logic        aw_got, w_got, ar_got;
        logic [31:0] aw_a, w_d, ar_a;
        logic        pend_aw, pend_w, pend_ar;
        logic [31:0] pend_awa, pend_wd, pend_ara;
        logic        viol_aw, viol_w, viol_ar;
        logic [31:0] wa [64];
        logic [31:0] wd [64];
        logic [31:0] ra [64];
        logic [31:0] mem [64];

        axil_pattern_gen_master #(
            .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
            .C_M_TARGET_BASE_ADDR(BASE), .C_M_TRANSACTIONS_NUM(n_of(g)),
            .C_PATTERN_MODE(g), .C_SEED(seed_of(g))
        ) u_dut (
            .ACLK(clk), .ARESET(rst), .INIT_AXI_TXN(init[g]),
            .TXN_DONE(s_done), .BUSY(s_busy), .ERROR(s_error), .ERR_COUNT(s_errc),
            .M_AXI_AWADDR(s_awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(s_awvalid),
            .M_AXI_AWREADY(awready), .M_AXI_WDATA(s_wdata), .M_AXI_WSTRB(wstrb),
            .M_AXI_WVALID(s_wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
            .M_AXI_BVALID(bvalid), .M_AXI_BREADY(s_bready), .M_AXI_ARADDR(araddr),
            .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
            .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
            .M_AXI_RREADY(rready)
        );

        assign done[g] = s_done;    assign busy[g] = s_busy;
        assign error[g] = s_error;  assign errc[g] = s_errc;
        assign awvalid[g] = s_awvalid; assign wvalid[g] = s_wvalid;
        assign bready[g] = s_bready;   assign awaddr[g] = s_awaddr;
        assign wdata[g] = s_wdata;
        assign wr_cnt[g] = wc;  assign rd_cnt[g] = rc;
        assign aw_hs[g] = ahs;  assign w_hs[g] = whs;
        assign ar_hs[g] = arhs; assign proto[g] = pc;
        assign wr_addr[g] = wa; assign wr_data[g] = wd; assign rd_addr[g] = ra;

        // A VALID left waiting must stay high with unchanged payload.
        assign viol_aw = pend_aw && (!s_awvalid || s_awaddr !== pend_awa);
        assign viol_w  = pend_w  && (!s_wvalid  || s_wdata  !== pend_wd);
        assign viol_ar = pend_ar && (!arvalid   || araddr   !== pend_ara);

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0;
                arready <= 1'b0; rvalid <= 1'b0;
                aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
                awc <= 0; wlc <= 0; arc <= 0;
                pend_aw <= 1'b0; pend_w <= 1'b0; pend_ar <= 1'b0;
                bresp <= 2'b00; rresp <= 2'b00; rdata <= 32'h0;
            end else begin
                pc <= pc + int'(viol_aw) + int'(viol_w) + int'(viol_ar);
                pend_aw <= s_awvalid && !awready; pend_awa <= s_awaddr;
                pend_w  <= s_wvalid && !wready;   pend_wd  <= s_wdata;
                pend_ar <= arvalid && !arready;   pend_ara <= araddr;

                if (s_awvalid && awready) begin
                    awready <= 1'b0; aw_got <= 1'b1; aw_a <= s_awaddr; awc <= 0; ahs <= ahs + 1;
                end else if (s_awvalid && !aw_got && !awready) begin
                    if (awc >= aw_lag[g]) awready <= 1'b1; else awc <= awc + 1;
                end
                if (s_wvalid && wready) begin
                    wready <= 1'b0; w_got <= 1'b1; w_d <= s_wdata; wlc <= 0; whs <= whs + 1;
                end else if (s_wvalid && !w_got && !wready) begin
                    if (wlc >= w_lag[g]) wready <= 1'b1; else wlc <= wlc + 1;
                end
                if (bvalid && s_bready) begin
                    bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
                end else if (aw_got && w_got && !bvalid && (!rnd_en[g] || $urandom_range(0, 2) == 0)) begin
                    bvalid <= 1'b1;
                    bresp <= (wc == bad_wr[g]) ? 2'b10 : 2'b00;
                    mem[aw_a[7:2]] <= w_d;
                    wa[wc[5:0]] <= aw_a; wd[wc[5:0]] <= w_d;
                    wc <= wc + 1;
                end

                if (arvalid && arready) begin
                    arready <= 1'b0; ar_got <= 1'b1; ar_a <= araddr; arc <= 0; arhs <= arhs + 1;
                end else if (arvalid && !ar_got && !arready) begin
                    if (arc >= aw_lag[g]) arready <= 1'b1; else arc <= arc + 1;
                end
                if (rvalid && rready) begin
                    rvalid <= 1'b0; ar_got <= 1'b0;
                end else if (ar_got && !rvalid && (!rnd_en[g] || $urandom_range(0, 2) == 0)) begin
                    rvalid <= 1'b1;
                    rresp <= 2'b00;
                    rdata <= mem[ar_a[7:2]] ^ ((rc == bad_rd[g]) ? 32'h8000_0001 : 32'h0);
                    ra[rc[5:0]] <= ar_a;
                    rc <= rc + 1;
                end

                if (clr[g]) begin
                    wc <= 0; rc <= 0; ahs <= 0; whs <= 0; arhs <= 0; pc <= 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int g, input int awl, input int wl, input bit rnd, input int bw, input int br);
        aw_lag[g] = awl; w_lag[g] = wl; rnd_en[g] = rnd; bad_wr[g] = bw; bad_rd[g] = br;
        @(negedge clk); clr[g] = 1'b1;
        @(negedge clk); clr[g] = 1'b0;
    endtask

    task automatic start_txn(input int g);
        @(negedge clk); init[g] = 1'b1;
        @(negedge clk); @(negedge clk); init[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget, input string tag);
        int n = 0;
        while (done[g] !== 1'b1 && n < budget) begin
            @(negedge clk); n++;
        end
        chk({tag, "_done_in_time"}, done[g], 1);
    endtask

    task automatic check_run(input int g, input int exp_err, input string tag);
        int n = n_of(g);
        repeat (3) @(negedge clk);
        chk({tag, "_done"}, done[g], 1);
        chk({tag, "_busy"}, busy[g], 0);
        chk({tag, "_err_count"}, errc[g], exp_err);
        chk({tag, "_error"}, error[g], exp_err != 0);
        chk({tag, "_writes"}, wr_cnt[g], n);
        chk({tag, "_reads"}, rd_cnt[g], n);
        chk({tag, "_aw_hs"}, aw_hs[g], n);
        chk({tag, "_w_hs"}, w_hs[g], n);
        chk({tag, "_ar_hs"}, ar_hs[g], n);
        chk({tag, "_valid_stable"}, proto[g], 0);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_waddr%0d", tag, i), wr_addr[g][i], BASE + 32'(4 * i));
            chk($sformatf("%s_wdata%0d", tag, i), wr_data[g][i], pat(g, seed_of(g), i));
            chk($sformatf("%s_raddr%0d", tag, i), rd_addr[g][i], BASE + 32'(4 * i));
        end
    endtask

    initial begin
        int n;
        for (int g = 0; g < 3; g++) begin
            init[g] = 1'b0; clr[g] = 1'b0; aw_lag[g] = 0; w_lag[g] = 0;
            bad_wr[g] = -1; bad_rd[g] = -1; rnd_en[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst%0d_awvalid", g), awvalid[g], 0);
            chk($sformatf("rst%0d_wvalid", g), wvalid[g], 0);
            chk($sformatf("rst%0d_bready", g), bready[g], 0);
            chk($sformatf("rst%0d_awaddr", g), awaddr[g], BASE);
            chk($sformatf("rst%0d_wdata", g), wdata[g], 0);
            chk($sformatf("rst%0d_done", g), done[g], 0);
            chk($sformatf("rst%0d_busy", g), busy[g], 0);
            chk($sformatf("rst%0d_errc", g), errc[g], 0);
            chk($sformatf("rst%0d_error", g), error[g], 0);
        end
        chk("rst_arvalid", g_dut[0].arvalid, 0);
        chk("rst_rready", g_dut[0].rready, 0);
        chk("rst_araddr", g_dut[0].araddr, BASE);
        rst = 1'b0;

        // Mode 0, zero-wait slave, with start latency checks.
        cfg(0, 0, 0, 0, -1, -1);
        @(negedge clk); init[0] = 1'b1;
        @(posedge clk); #1;
        chk("t1_busy_edge_k", busy[0], 0);
        chk("t1_awvalid_edge_k", awvalid[0], 0);
        @(posedge clk); #1;
        chk("t1_busy_edge_k1", busy[0], 1);
        chk("t1_awvalid_edge_k1", awvalid[0], 1);
        chk("t1_wvalid_edge_k1", wvalid[0], 1);
        chk("t1_awaddr0", awaddr[0], BASE);
        chk("t1_wdata0", wdata[0], pat(0, 32'h0, 0));
        chk("t1_wstrb", g_dut[0].wstrb, 4'hF);
        chk("t1_awprot", g_dut[0].awprot, 0);
        chk("t1_arprot", g_dut[0].arprot, 0);
        @(negedge clk); init[0] = 1'b0;
        wait_done(0, 500, "t1");
        check_run(0, 0, "t1");

        // SLVERR on write 1 and corrupted read data on word 2.
        cfg(0, 1, 0, 1, 1, 2);
        start_txn(0);
        chk("t3_done_cleared", done[0], 0);
        wait_done(0, 2000, "t3");
        check_run(0, 2, "t3");

        // Clean rerun must start from a zero count.
        cfg(0, 0, 1, 1, -1, -1);
        start_txn(0);
        chk("t3b_errc_cleared", errc[0], 0);
        wait_done(0, 2000, "t3b");
        check_run(0, 0, "t3b");

        // Mode 1, 40 words, random response delays.
        cfg(1, 1, 2, 1, -1, -1);
        start_txn(1);
        wait_done(1, 8000, "t2");
        check_run(1, 0, "t2");
        chk("t2_walk_word33", wr_data[1][33], 32'h0000_0002);

        // Mode 2 with seed wrap; W accepted 3 cycles before AW, then the reverse.
        cfg(2, 3, 0, 1, -1, -1);
        start_txn(2);
        wait_done(2, 3000, "t4a");
        check_run(2, 0, "t4a");
        cfg(2, 0, 3, 1, -1, -1);
        start_txn(2);
        wait_done(2, 3000, "t4b");
        check_run(2, 0, "t4b");

        // Reset during the third write.
        cfg(0, 0, 0, 0, -1, -1);
        start_txn(0);
        n = 0;
        while (!(wr_cnt[0] >= 2 && awvalid[0] === 1'b1) && n < 200) begin
            @(negedge clk); n++;
        end
        chk("t5_third_write_reached", (wr_cnt[0] >= 2 && awvalid[0] === 1'b1), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_awvalid", awvalid[0], 0);
        chk("t5_wvalid", wvalid[0], 0);
        chk("t5_bready", bready[0], 0);
        chk("t5_busy", busy[0], 0);
        chk("t5_done", done[0], 0);
        chk("t5_awaddr", awaddr[0], BASE);
        chk("t5_wdata", wdata[0], 0);
        @(negedge clk); rst = 1'b0;
        cfg(0, 0, 0, 1, -1, -1);
        start_txn(0);
        wait_done(0, 2000, "t5");
        check_run(0, 0, "t5");

        // Second INIT while busy is dropped.
        cfg(1, 0, 0, 1, -1, -1);
        start_txn(1);
        repeat (30) @(negedge clk);
        chk("t6_busy_mid", busy[1], 1);
        start_txn(1);
        wait_done(1, 8000, "t6");
        check_run(1, 0, "t6");
        repeat (20) @(negedge clk);
        chk("t6_no_rerun_busy", busy[1], 0);
        chk("t6_no_rerun_writes", wr_cnt[1], 40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
